// File: rtl/reg_bist_pkg.sv
// reg_bist_pkg: shared FSM encoding, pattern count and pattern-index constants for reg_bist.
// No ports. Constants are given for the default 16-bit width; rebase() moves an
// index constant to another width, because every index is defined relative to WIDTH.
package reg_bist_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int NPAT      = DEF_WIDTH + 4;
    localparam int IDX_ONES  = DEF_WIDTH + 1;
    localparam int IDX_AA    = DEF_WIDTH + 2;
    localparam int IDX_55    = DEF_WIDTH + 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        HOLD  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic int rebase(input int idx, input int width);
        return idx - DEF_WIDTH + width;
    endfunction

endpackage

// File: rtl/reg_bist_patgen.sv
// reg_bist_patgen: combinational pattern table, index -> test pattern.
// Ports:
//   i_idx  pattern index, 0..NPAT-1
//   o_pat  pattern: 0, walking one (idx 1..WIDTH), all ones, 1010..., 0101...
//          Indices beyond the table give 0.
module reg_bist_patgen
    import reg_bist_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IW    = $clog2(rebase(NPAT, WIDTH))
) (
    input  logic [IW-1:0]    i_idx,
    output logic [WIDTH-1:0] o_pat
);

    localparam int ONES = rebase(IDX_ONES, WIDTH);
    localparam int AA   = rebase(IDX_AA, WIDTH);
    localparam int P55  = rebase(IDX_55, WIDTH);

    logic [WIDTH-1:0] w_alt;
    int               w_i;

    // w_alt has the odd bits set (0xAAAA at 16 bits); its complement is 0x5555.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) w_alt[i] = i[0];
        w_i   = int'(i_idx);
        o_pat = (w_i == 0)     ? '0 :
                (w_i <= WIDTH) ? WIDTH'(1) << (i_idx - IW'(1)) :
                (w_i == ONES)  ? '1 :
                (w_i == AA)    ? w_alt :
                (w_i == P55)   ? ~w_alt : '0;
    end

endmodule

// File: rtl/reg_bist.sv
// reg_bist: autonomous write/hold/read-back self test of a load-enable register.
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       begins a run when idle or done; ignored while busy
//   reg_out     output of the register under test
//   reg_in      drives the register data input
//   reg_load    drives the register load enable
//   busy        high during WRITE/HOLD/CHECK
//   done        high from the end of a run until the next start
//   pass        1 when every pattern read back correctly (valid with done)
//   fail_index  index of the first failing pattern, 0 on pass
//   fail_data   reg_out observed at the first failure, 0 on pass
module reg_bist
    import reg_bist_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    localparam int NP    = rebase(NPAT, WIDTH),
    localparam int IW    = $clog2(NP)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] reg_out,
    output logic [WIDTH-1:0] reg_in,
    output logic             reg_load,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [IW-1:0]    fail_index,
    output logic [WIDTH-1:0] fail_data
);

    state_t           r_state;
    state_t           w_next;
    logic [IW-1:0]    r_idx;
    logic             r_pass;
    logic [IW-1:0]    r_fail_index;
    logic [WIDTH-1:0] r_fail_data;
    logic [WIDTH-1:0] w_pat;
    logic             w_go;
    logic             w_last;
    logic             w_miss;

    reg_bist_patgen #(.WIDTH(WIDTH), .IW(IW)) u_patgen (
        .i_idx (r_idx),
        .o_pat (w_pat)
    );

    assign w_go   = (r_state == IDLE || r_state == DONE) && start;
    assign w_last = r_idx == IW'(NP - 1);
    assign w_miss = reg_out != w_pat;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: w_next = start ? WRITE : r_state;
            WRITE:      w_next = HOLD;
            HOLD:       w_next = CHECK;
            CHECK:      w_next = (w_miss || w_last) ? DONE : WRITE;
            default:    w_next = IDLE;
        endcase
    end

    // Data side decodes from state and idx only. HOLD and CHECK drive the
    // complement so a register that loads with load=0 is caught.
    assign reg_load   = r_state == WRITE;
    assign reg_in     = (r_state == WRITE) ? w_pat :
                        (r_state == HOLD || r_state == CHECK) ? ~w_pat : '0;
    assign busy       = r_state == WRITE || r_state == HOLD || r_state == CHECK;
    assign done       = r_state == DONE;
    assign pass       = r_pass;
    assign fail_index = r_fail_index;
    assign fail_data  = r_fail_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_pass       <= 1'b0;
            r_fail_index <= '0;
            r_fail_data  <= '0;
        end else begin
            r_state <= w_next;
            if (w_go) begin
                r_idx        <= '0;
                r_pass       <= 1'b0;
                r_fail_index <= '0;
                r_fail_data  <= '0;
            end else if (r_state == CHECK) begin
                if (w_miss) begin
                    r_fail_index <= r_idx;
                    r_fail_data  <= reg_out;
                end else if (w_last) begin
                    r_pass <= 1'b1;
                end else begin
                    r_idx <= r_idx + IW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_bist.sv
// tb_reg_bist: scoreboarded bench driving reg_bist against good and faulty register models.
module tb_reg_bist;
    import reg_bist_pkg::*;

    localparam int W  = 16;
    localparam int IW = 5;

    typedef struct {
        logic          pass;
        logic [IW-1:0] fi;
        logic [W-1:0]  fd;
        int            cycles;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  reg_out, reg_in, fail_data;
    logic          reg_load, busy, done, pass;
    logic [IW-1:0] fail_index;
    logic [IW-1:0] pg_idx = '0;
    logic [W-1:0]  pg_pat;
    logic [W-1:0]  m_reg = '0;
    int            mode = 0;
    int            errors = 0;
    int            checks = 0;
    exp_t          sb[$];

    always #5 clk = ~clk;

    // Register model: 0 good, 1 bit 3 stuck at 0, 2 ignores load, 3 never loads.
    always @(posedge clk)
        m_reg <= (mode == 3) ? '0 : (mode == 2 || reg_load) ? reg_in : m_reg;
    assign reg_out = (mode == 1) ? (m_reg & ~16'h0008) : m_reg;

    reg_bist dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .reg_out    (reg_out),
        .reg_in     (reg_in),
        .reg_load   (reg_load),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_index (fail_index),
        .fail_data  (fail_data)
    );

    reg_bist_patgen #(.WIDTH(W), .IW(IW)) u_pg (.i_idx(pg_idx), .o_pat(pg_pat));

    function automatic logic [W-1:0] bpat(input int i);
        case (i)
            0:       return 16'h0000;
            17:      return 16'hFFFF;
            18:      return 16'hAAAA;
            19:      return 16'h5555;
            default: return 16'h0001 << (i - 1);
        endcase
    endfunction

    // Value CHECK would see for pattern i under each register model.
    function automatic exp_t model(input int md);
        exp_t e;
        logic [W-1:0] p, obs;
        for (int i = 0; i < 20; i++) begin
            p   = bpat(i);
            obs = (md == 1) ? (p & 16'hFFF7) : (md == 2) ? ~p : (md == 3) ? 16'h0000 : p;
            if (obs != p) begin
                e.pass = 1'b0; e.fi = IW'(i); e.fd = obs; e.cycles = 3 * (i + 1);
                return e;
            end
        end
        e.pass = 1'b1; e.fi = '0; e.fd = '0; e.cycles = 60;
        return e;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit to);
        cyc = 0;
        to  = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (done) begin
                to = 1'b0;
                break;
            end
            if (busy) cyc++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (reg_load !== 1'b0) begin errors++; $display("FAIL reset_load got=%b want=0", reg_load); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got=%b want=0", pass); end
        checks++; if (reg_in !== 16'h0) begin errors++; $display("FAIL reset_in got=%h want=0000", reg_in); end
        checks++; if (fail_data !== 16'h0 || fail_index !== 5'd0) begin errors++; $display("FAIL reset_fail got=%0d/%h want=0/0000", fail_index, fail_data); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL idle_quiet got busy=%b done=%b want=0/0", busy, done); end
    endtask

    task automatic test_patgen();
        for (int i = 0; i < 20; i++) begin
            pg_idx = IW'(i);
            #1;
            checks++;
            if (pg_pat !== bpat(i)) begin errors++; $display("FAIL patgen[%0d] got=%h want=%h", i, pg_pat, bpat(i)); end
        end
    endtask

    task automatic test_runs();
        int cyc;
        bit to;
        exp_t e;
        for (int md = 0; md < 4; md++) begin
            mode = md;
            sb.push_back(model(md));
            pulse_start();
            wait_done(cyc, to);
            checks++;
            if (to || sb.size() == 0) begin
                errors++; $display("FAIL run%0d_timeout done=%b queued=%0d want done=1", md, done, sb.size());
                sb.delete();
                continue;
            end
            e = sb.pop_front();
            if (pass !== e.pass || fail_index !== e.fi || fail_data !== e.fd) begin
                errors++; $display("FAIL run%0d_result got pass=%b idx=%0d data=%h want pass=%b idx=%0d data=%h", md, pass, fail_index, fail_data, e.pass, e.fi, e.fd);
            end
            checks++; if (cyc != e.cycles) begin errors++; $display("FAIL run%0d_busy_cycles got=%0d want=%0d", md, cyc, e.cycles); end
            @(negedge clk);
            checks++; if (done !== 1'b1 || pass !== e.pass) begin errors++; $display("FAIL run%0d_hold got done=%b pass=%b want 1/%b", md, done, pass, e.pass); end
        end
        mode = 0;
    endtask

    task automatic test_reset_midrun();
        int cyc;
        bit to;
        exp_t e;
        pulse_start();
        repeat (31) @(negedge clk);
        checks++; if (reg_load !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL midrun_pre got load=%b busy=%b want 1/1", reg_load, busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (reg_load !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || reg_in !== 16'h0) begin errors++; $display("FAIL midrun_async got load=%b busy=%b done=%b in=%h want 0/0/0/0000", reg_load, busy, done, reg_in); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (done !== 1'b0 || pass !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrun_idle got done=%b pass=%b busy=%b want 0/0/0", done, pass, busy); end
        sb.push_back(model(0));
        pulse_start();
        wait_done(cyc, to);
        checks++;
        if (to || sb.size() == 0) begin
            errors++; $display("FAIL midrun_rerun_timeout done=%b want 1", done);
            sb.delete();
        end else begin
            e = sb.pop_front();
            if (pass !== e.pass || fail_index !== e.fi || cyc != e.cycles) begin
                errors++; $display("FAIL midrun_rerun got pass=%b idx=%0d cyc=%0d want pass=%b idx=%0d cyc=%0d", pass, fail_index, cyc, e.pass, e.fi, e.cycles);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc, extra;
        bit to;
        exp_t e;
        extra = 0;
        sb.push_back(model(0));
        sb.push_back(model(0));
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_done(cyc, to);
            checks++;
            if (to || sb.size() == 0) begin
                errors++; $display("FAIL b2b%0d_timeout done=%b want 1", k, done);
                sb.delete();
                break;
            end
            e = sb.pop_front();
            if (pass !== e.pass || cyc + extra != e.cycles) begin
                errors++; $display("FAIL b2b%0d_result got pass=%b cyc=%0d want pass=%b cyc=%0d", k, pass, cyc + extra, e.pass, e.cycles);
            end
            if (k == 0) begin
                @(negedge clk);
                extra = 1;
                checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_done_width got done=%b busy=%b want 0/1", done, busy); end
            end
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_settle got done=%b busy=%b want 1/0", done, busy); end
    endtask

    initial begin
        test_reset();
        test_patgen();
        test_runs();
        test_reset_midrun();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
